// File: rtl/window_buffer.sv
// window_buffer: 3x3 pixel window with load, shift and refill addressing.
// Reads write one slot, shifts move rows/columns; all outputs are registered.
module window_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_read,
    input  logic       start_shift,
    input  logic [1:0] shift_direc,
    input  logic [7:0] data_r,
    input  logic [3:0] count,
    output logic       read_done,
    output logic       shift_done,
    output logic [7:0] windowBufferOut [0:8],
    output logic [3:0] count_o
);

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic       refill_q;
    logic [1:0] dir_q;
    logic [3:0] slot;
    logic       wr_ok;
    logic [3:0] next_cnt;
    logic       refill_eff;
    logic [7:0] win_d [0:8];

    // Map the read index to a window slot (load map or refill line)
    always_comb begin
        slot       = 4'd0;
        wr_ok      = (count <= 4'd8);
        next_cnt   = wr_ok ? (count + 4'd1) : 4'd9;
        refill_eff = refill_q && (count != 4'd0);
        if (refill_eff && count >= 4'd6 && count <= 4'd8) begin
            case (dir_q)
                DIR_LEFT: begin
                    case (count)
                        4'd6:    slot = 4'd2;
                        4'd7:    slot = 4'd5;
                        default: slot = 4'd8;
                    endcase
                end
                DIR_UP: begin
                    case (count)
                        4'd6:    slot = 4'd6;
                        4'd7:    slot = 4'd7;
                        default: slot = 4'd8;
                    endcase
                end
                DIR_RIGHT: begin
                    case (count)
                        4'd6:    slot = 4'd0;
                        4'd7:    slot = 4'd3;
                        default: slot = 4'd6;
                    endcase
                end
                default: slot = 4'd0;
            endcase
        end else begin
            case (count)
                4'd0:    slot = 4'd6;
                4'd1:    slot = 4'd7;
                4'd2:    slot = 4'd8;
                4'd3:    slot = 4'd3;
                4'd4:    slot = 4'd4;
                4'd5:    slot = 4'd5;
                4'd6:    slot = 4'd0;
                4'd7:    slot = 4'd1;
                4'd8:    slot = 4'd2;
                default: slot = 4'd0;
            endcase
        end
    end

    // Next window contents: a shift wins over a read
    always_comb begin
        win_d = windowBufferOut;
        if (start_shift) begin
            case (shift_direc)
                DIR_LEFT: begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*3]   = windowBufferOut[r*3+1];
                        win_d[r*3+1] = windowBufferOut[r*3+2];
                    end
                end
                DIR_UP: begin
                    for (int c = 0; c < 3; c++) begin
                        win_d[c]   = windowBufferOut[3+c];
                        win_d[3+c] = windowBufferOut[6+c];
                    end
                end
                DIR_RIGHT: begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r*3+2] = windowBufferOut[r*3+1];
                        win_d[r*3+1] = windowBufferOut[r*3];
                    end
                end
                default: ;
            endcase
        end else if (start_read && wr_ok) begin
            win_d[slot] = data_r;
        end
    end

    // Window storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                windowBufferOut[i] <= 8'd0;
            end
        end else begin
            windowBufferOut <= win_d;
        end
    end

    // Handshake pulses, read index and refill mode tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o    <= 4'd0;
            read_done  <= 1'b0;
            shift_done <= 1'b0;
            refill_q   <= 1'b0;
            dir_q      <= DIR_NONE;
        end else begin
            read_done  <= 1'b0;
            shift_done <= 1'b0;
            if (start_shift) begin
                shift_done <= 1'b1;
                if (shift_direc != DIR_NONE) begin
                    count_o  <= 4'd6;
                    dir_q    <= shift_direc;
                    refill_q <= 1'b1;
                end
            end else if (start_read) begin
                read_done <= 1'b1;
                count_o   <= next_cnt;
                if (count == 4'd0) begin
                    refill_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: table vectors, directed corner sequences and
// randomized traffic checked against a row/column reference model.
module tb_window_buffer;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_read = 1'b0;
    logic       start_shift = 1'b0;
    logic [1:0] shift_direc = 2'b00;
    logic [7:0] data_r = 8'd0;
    logic [3:0] count = 4'd0;
    logic       read_done;
    logic       shift_done;
    logic [7:0] win [0:8];
    logic [3:0] count_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_win [9];
    logic [3:0] m_cnt;
    logic       m_rd;
    logic       m_sd;
    logic       m_refill;
    logic [1:0] m_dir;

    typedef struct {
        logic [3:0] cnt;
        logic [7:0] dat;
        logic [3:0] exp_cnt;
        logic [3:0] exp_slot;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] exp_w [9];
    logic [7:0] load_dat [9];

    always #5 tb_clk = ~tb_clk;

    window_buffer dut (
        .clk            (tb_clk),
        .rst            (rst),
        .start_read     (start_read),
        .start_shift    (start_shift),
        .shift_direc    (shift_direc),
        .data_r         (data_r),
        .count          (count),
        .read_done      (read_done),
        .shift_done     (shift_done),
        .windowBufferOut(win),
        .count_o        (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s[%0d]", name, i), 32'(win[i]), 32'(exp_w[i]));
        end
    endtask

    // Reference: window seen as rows/cols; load fills bottom row first.
    task automatic model_step(input logic r, input logic sr,
                              input logic ss, input logic [1:0] d,
                              input logic [3:0] c, input logic [7:0] dat);
        logic [7:0] old [9];
        int row;
        int col;
        int s;
        if (r) begin
            for (int i = 0; i < 9; i++) m_win[i] = 8'd0;
            m_cnt = 4'd0; m_rd = 1'b0; m_sd = 1'b0;
            m_refill = 1'b0; m_dir = 2'b00;
        end else if (ss) begin
            m_sd = 1'b1; m_rd = 1'b0;
            old = m_win;
            for (int rr = 0; rr < 3; rr++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    if (d == 2'b01 && cc < 2) m_win[rr*3+cc] = old[rr*3+cc+1];
                    if (d == 2'b10 && rr < 2) m_win[rr*3+cc] = old[(rr+1)*3+cc];
                    if (d == 2'b11 && cc > 0) m_win[rr*3+cc] = old[rr*3+cc-1];
                end
            end
            if (d != 2'b00) begin
                m_cnt = 4'd6; m_dir = d; m_refill = 1'b1;
            end
        end else if (sr) begin
            m_rd = 1'b1; m_sd = 1'b0;
            if (c == 4'd0) m_refill = 1'b0;
            if (c <= 4'd8) begin
                if (m_refill && c >= 4'd6) begin
                    if (m_dir == 2'b01) begin row = int'(c) - 6; col = 2; end
                    else if (m_dir == 2'b10) begin row = 2; col = int'(c) - 6; end
                    else begin row = int'(c) - 6; col = 0; end
                end else begin
                    row = 2 - int'(c) / 3;
                    col = int'(c) % 3;
                end
                s = row * 3 + col;
                m_win[s] = dat;
                m_cnt = c + 4'd1;
            end else begin
                m_cnt = 4'd9;
            end
        end else begin
            m_rd = 1'b0; m_sd = 1'b0;
        end
    endtask

    task automatic cyc(input logic r, input logic sr, input logic ss,
                       input logic [1:0] d, input logic [3:0] c,
                       input logic [7:0] dat);
        rst = r; start_read = sr; start_shift = ss;
        shift_direc = d; count = c; data_r = dat;
        @(posedge tb_clk);
        model_step(r, sr, ss, d, c, dat);
        #1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("model_win[%0d]", i), 32'(win[i]), 32'(m_win[i]));
        end
        chk("model_count_o", 32'(count_o), 32'(m_cnt));
        chk("model_read_done", 32'(read_done), 32'(m_rd));
        chk("model_shift_done", 32'(shift_done), 32'(m_sd));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 8'd0);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd3, 8'h55);
    endtask

    task automatic load_all();
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'b00, count_o, load_dat[k]);
            chk("load_read_done", 32'(read_done), 32'd1);
        end
    endtask

    initial begin
        load_dat = '{8'd6, 8'd7, 8'd8, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        vecs[0]  = '{4'd0, 8'd6, 4'd1, 4'd6};
        vecs[1]  = '{4'd1, 8'd7, 4'd2, 4'd7};
        vecs[2]  = '{4'd2, 8'd8, 4'd3, 4'd8};
        vecs[3]  = '{4'd3, 8'd3, 4'd4, 4'd3};
        vecs[4]  = '{4'd4, 8'd4, 4'd5, 4'd4};
        vecs[5]  = '{4'd5, 8'd5, 4'd6, 4'd5};
        vecs[6]  = '{4'd6, 8'd0, 4'd7, 4'd0};
        vecs[7]  = '{4'd7, 8'd1, 4'd8, 4'd1};
        vecs[8]  = '{4'd8, 8'd2, 4'd9, 4'd2};
        vecs[9]  = '{4'd9, 8'hEE, 4'd9, 4'd15};
        vecs[10] = '{4'd12, 8'hDD, 4'd9, 4'd15};

        // Reset: two cycles with competing requests
        do_reset();
        exp_w = '{default: 8'd0};
        chk_win("reset_win");
        chk("reset_count_o", 32'(count_o), 32'd0);
        chk("reset_read_done", 32'(read_done), 32'd0);
        chk("reset_shift_done", 32'(shift_done), 32'd0);

        // Table-driven load including out-of-range counts
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'b00, vecs[i].cnt, vecs[i].dat);
            chk($sformatf("vec%0d_count_o", i), 32'(count_o),
                32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_read_done", i), 32'(read_done), 32'd1);
            chk($sformatf("vec%0d_shift_done", i), 32'(shift_done), 32'd0);
            if (vecs[i].exp_slot != 4'd15) begin
                chk($sformatf("vec%0d_slot", i),
                    32'(win[vecs[i].exp_slot]), 32'(vecs[i].dat));
            end
        end
        exp_w = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        chk_win("load_win");

        // Idle: pulses drop, state holds
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 4'd0, 8'hFF);
        chk("idle_read_done", 32'(read_done), 32'd0);
        chk("idle_shift_done", 32'(shift_done), 32'd0);
        chk("idle_count_o", 32'(count_o), 32'd9);
        chk_win("idle_win");

        // Held read at count 0
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 8'd6);
            chk("held_read_done", 32'(read_done), 32'd1);
        end
        exp_w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd0, 8'd0};
        chk_win("held_win");
        chk("held_count_o", 32'(count_o), 32'd1);

        // Shift left then up
        do_reset();
        load_all();
        chk("load_count_o", 32'(count_o), 32'd9);
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 8'd0);
        exp_w = '{8'd1, 8'd2, 8'd2, 8'd4, 8'd5, 8'd5, 8'd7, 8'd8, 8'd8};
        chk_win("left_win");
        chk("left_count_o", 32'(count_o), 32'd6);
        chk("left_shift_done", 32'(shift_done), 32'd1);
        chk("left_read_done", 32'(read_done), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 8'd0);
        exp_w = '{8'd4, 8'd5, 8'd5, 8'd7, 8'd8, 8'd8, 8'd7, 8'd8, 8'd8};
        chk_win("up_win");
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 8'd0);
        chk_win("none_win");
        chk("none_shift_done", 32'(shift_done), 32'd1);
        chk("none_count_o", 32'(count_o), 32'd6);

        // Shift right then refill the left column
        do_reset();
        load_all();
        cyc(1'b0, 1'b0, 1'b1, 2'b11, 4'd0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd6, 8'd9);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd7, 8'd10);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd8, 8'd11);
        exp_w = '{8'd9, 8'd0, 8'd1, 8'd10, 8'd3, 8'd4, 8'd11, 8'd6, 8'd7};
        chk_win("refill_win");
        chk("refill_count_o", 32'(count_o), 32'd9);

        // Read at count 0 leaves refill mode: count 6 uses load map again
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 8'd20);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd6, 8'd21);
        chk("exit_refill_slot6", 32'(win[6]), 32'd20);
        chk("exit_refill_slot0", 32'(win[0]), 32'd21);

        // Read and shift together: shift wins
        do_reset();
        load_all();
        cyc(1'b0, 1'b1, 1'b1, 2'b01, 4'd3, 8'hAA);
        exp_w = '{8'd1, 8'd2, 8'd2, 8'd4, 8'd5, 8'd5, 8'd7, 8'd8, 8'd8};
        chk_win("prio_win");
        chk("prio_read_done", 32'(read_done), 32'd0);
        chk("prio_shift_done", 32'(shift_done), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int op;
            logic r;
            logic [3:0] c;
            op = int'($urandom_range(0, 9));
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 3) != 0) ? count_o
                                             : 4'($urandom_range(0, 15));
            cyc(r, op < 6 || op == 8, op >= 6 && op <= 8,
                2'($urandom_range(0, 3)), c, 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 The block SHALL use a single clock with a synchronous, active-high reset.
REQ-002 The block SHALL have the following ports:
- clk, input, 1 bit: rising-edge clock.
- rst, input, 1 bit: reset; synchronous, active-high.
- start_read, input, 1 bit: write data_r into the window slot selected by count.
- start_shift, input, 1 bit: shift the window in direction shift_direc.
- shift_direc, input, 2 bits: 00 none, 01 left, 10 up, 11 right.
- data_r, input, 8 bits: pixel to store.
- count, input, 4 bits: read index supplied by the controller (0..8).
- read_done, output, 1 bit: one-cycle pulse after a read.
- shift_done, output, 1 bit: one-cycle pulse after a shift.
- windowBufferOut, output, array [0:8] of 8 bits: 3x3 window, row-major; index = row*3 + col; row 0 is the top.
- count_o, output, 4 bits: next read index, registered.

Function
REQ-003 All outputs SHALL be registered; every update SHALL occur on the rising clk edge after the request is sampled high.
REQ-004 Load mode: a read at count k SHALL write data_r to slot L[k], with L = {6,7,8,3,4,5,0,1,2}; the bottom row fills first, then the middle row, then the top row.
REQ-005 On each read the block SHALL set count_o = count+1, saturating at 9, and assert read_done for exactly one cycle.
REQ-006 start_read held high with count unchanged SHALL rewrite the same slot each cycle.
- read_done SHALL stay high while start_read stays high.
- This repetition SHALL have no other side effect.
REQ-007 A count value of 9..15 during a read SHALL write nothing, hold count_o at 9, and still pulse read_done.
REQ-008 Shift 01 (left) SHALL perform, simultaneously:
- col0 <= col1 and col1 <= col2 for each row.
- col2 SHALL keep its old value.
REQ-009 Shift 10 (up) SHALL perform, simultaneously:
- row0 <= row1 and row1 <= row2.
- row2 SHALL keep its old value.
REQ-010 Shift 11 (right) SHALL perform, simultaneously:
- col2 <= col1 and col1 <= col0.
- col0 SHALL keep its old value.
REQ-011 Shift 00 SHALL leave the window unchanged and still pulse shift_done.
REQ-012 On every shift the block SHALL assert shift_done for one cycle.
REQ-013 A shift with direction 01, 10 or 11 SHALL also:
- set count_o to 6;
- latch the direction;
- enter refill mode.
REQ-014 In refill mode, reads at counts 6, 7 and 8 SHALL write the vacated line:
- left: slots 2, 5, 8;
- up: slots 6, 7, 8;
- right: slots 0, 3, 6.
REQ-015 In refill mode, reads at counts 0..5 SHALL use the load-mode map L.
REQ-016 A read at count 0 SHALL clear refill mode before the write is mapped.
REQ-017 If start_read and start_shift are both high in the same cycle, the shift SHALL take priority and the read SHALL be ignored: no write and no read_done.
REQ-018 read_done and shift_done SHALL never be high in the same cycle.
REQ-019 When neither request is high, all state SHALL hold, and read_done and shift_done SHALL be 0 in the following cycle.

Reset
REQ-020 While rst = 1 at a rising clk edge, all nine window slots SHALL become 0.
REQ-021 While rst = 1 at a rising clk edge, count_o, read_done and shift_done SHALL become 0.
REQ-022 While rst = 1 at a rising clk edge, refill mode SHALL be cleared and the latched direction SHALL become 00.
REQ-023 Reset SHALL override any concurrent read or shift, including mid-load or mid-refill.

Verification
REQ-024 Reset: assert rst for 2 cycles -> all windowBufferOut slots = 0, count_o = 0, read_done = 0, shift_done = 0.
REQ-025 Load: reads of data 6,7,8,3,4,5,0,1,2 at counts 0..8, feeding count_o back into count -> window = {0,1,2,3,4,5,6,7,8}, final count_o = 9, read_done pulses each read.
REQ-026 Held read: start_read held high at count 0 with data_r = 6 for 12 cycles -> slot 6 = 6, count_o = 1, other slots = 0.
REQ-027 Shifts from window {0..8}:
- left -> {1,2,2,4,5,5,7,8,8}, count_o = 6, shift_done pulse;
- then up -> {4,5,5,7,8,8,7,8,8}.
REQ-028 Refill: from window {0..8}, shift right, then reads at counts 6,7,8 with data 9,10,11 -> slots 0, 3, 6 = 9, 10, 11 and slots 1,2,4,5,7,8 = 0,1,3,4,6,7.
REQ-029 Priority: start_read and start_shift (01) both high for one cycle -> shift performed, window unchanged by data_r, read_done = 0, shift_done = 1.
